// File: rtl/tbus_mem_responder_pkg.sv
// tbus_mem_responder_pkg: shared TBUS bus ranges, op codes, request record and masked-merge helper
`ifndef TBUS_DEFINES
`define TBUS_DEFINES
`define RESULT_RANGE 63:0
`define SRC_RANGE 63:0
`define TBUS_OPTYPE_RANGE 1:0
`endif

package tbus_mem_responder_pkg;
  localparam logic [`TBUS_OPTYPE_RANGE] TBUS_READ  = 2'd0;
  localparam logic [`TBUS_OPTYPE_RANGE] TBUS_WRITE = 2'd1;
  typedef struct packed {
    logic [`RESULT_RANGE]      index;
    logic [`SRC_RANGE]         data;
    logic [63:0]               mask;
    logic [`TBUS_OPTYPE_RANGE] op;
  } tbus_req_t;
  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [63:0] m);
    return (old & ~m) | (d & m);
  endfunction
endpackage

// File: rtl/tbus_mem_responder_if.sv
// tbus_mem_responder_if: TBUS request/response bundle
// master: requester drives valid/index/write_data/write_mask/operation_type
// slave:  responder drives index_ready/read_data/operation_done
interface tbus_mem_responder_if;
  logic                      tbus_index_valid;
  logic                      tbus_index_ready;
  logic [`RESULT_RANGE]      tbus_index;
  logic [`SRC_RANGE]         tbus_write_data;
  logic [63:0]               tbus_write_mask;
  logic [`TBUS_OPTYPE_RANGE] tbus_operation_type;
  logic [`RESULT_RANGE]      tbus_read_data;
  logic                      tbus_operation_done;
  modport master (
    output tbus_index_valid, tbus_index, tbus_write_data, tbus_write_mask, tbus_operation_type,
    input  tbus_index_ready, tbus_read_data, tbus_operation_done
  );
  modport slave (
    input  tbus_index_valid, tbus_index, tbus_write_data, tbus_write_mask, tbus_operation_type,
    output tbus_index_ready, tbus_read_data, tbus_operation_done
  );
endinterface

// File: rtl/tbus_mem_array.sv
// tbus_mem_array: 2^DEPTH_LOG x 64-bit storage, bit-masked synchronous write, registered read
// clock, reset_n (clears only the read register), we/re strobes, addr, wdata, wmask, rdata
module tbus_mem_array
  import tbus_mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 we,
  input  logic                 re,
  input  logic [DEPTH_LOG-1:0] addr,
  input  logic [63:0]          wdata,
  input  logic [63:0]          wmask,
  output logic [63:0]          rdata
);
  logic [63:0] mem [0:(1<<DEPTH_LOG)-1];
  always_ff @(posedge clock)
    if (we) mem[addr] <= merge(mem[addr], wdata, wmask);
  // rdata holds the last read result until the next read completes
  always_ff @(posedge clock)
    rdata <= !reset_n ? '0 : re ? mem[addr] : rdata;
endmodule

// File: rtl/tbus_mem_responder.sv
// tbus_mem_responder: fixed-latency TBUS memory responder (IDLE -> BUSY -> DONE)
// clock, reset_n (sync active-low), bus: slave side of tbus_mem_responder_if
module tbus_mem_responder
  import tbus_mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  tbus_mem_responder_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t    state;
  logic [3:0] cnt;
  tbus_req_t req, cur;
  logic      take, acc, unused_idx;
  assign bus.tbus_index_ready    = state == IDLE;
  assign bus.tbus_operation_done = state == DONE;
  assign take = bus.tbus_index_valid & bus.tbus_index_ready;
  // with LATENCY==1 the access happens on the accept edge, straight from the bus fields
  assign cur  = state == IDLE ? {bus.tbus_index, bus.tbus_write_data, bus.tbus_write_mask, bus.tbus_operation_type} : req;
  // the access commits on the edge that enters DONE; reset on that edge aborts it
  assign acc  = reset_n & (LATENCY == 1 ? take : state == BUSY && cnt == 4'd1);
  assign unused_idx = ^{cur.index[63:DEPTH_LOG+3], cur.index[2:0]};
  always_ff @(posedge clock)
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else
      case (state)
        IDLE: if (take) begin
          req   <= cur;
          cnt   <= 4'(LATENCY - 1);
          state <= LATENCY == 1 ? DONE : BUSY;
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= DONE;
        end
        default: state <= IDLE;
      endcase
  tbus_mem_array #(.DEPTH_LOG(DEPTH_LOG)) u_mem (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (acc && cur.op == TBUS_WRITE),
    .re      (acc && cur.op == TBUS_READ),
    .addr    (cur.index[DEPTH_LOG+2:3]),
    .wdata   (cur.data),
    .wmask   (cur.mask),
    .rdata   (bus.tbus_read_data)
  );
endmodule
